// File: rtl/mont_exp_ctrl.sv
// Montgomery modular exponentiation sequencer.
// Computes result = in_x^in_e mod in_m by issuing Montgomery products on the
// external mm_* multiplier port (left-to-right square-and-multiply).
// Optional feature macro MONT_EXP_SKIP_LZ_EN: when defined, the square/multiply
// loop starts at the most significant set bit of the exponent instead of at
// EXP_WIDTH-1. The result is identical in both builds; only the operation
// count and latency differ.
//
// state      | meaning
// IDLE       | waiting for start
// XM_ISSUE   | mm(x, r2) requested -> xm (x in Montgomery form)
// XM_WAIT    | waiting for xm
// ONE_ISSUE  | mm(r2, 1) requested -> acc = R mod M
// ONE_WAIT   | waiting for acc
// SQR_ISSUE  | mm(acc, acc) requested
// SQR_WAIT   | waiting for square
// MUL_ISSUE  | mm(acc, xm) requested (exponent bit is 1)
// MUL_WAIT   | waiting for multiply
// FROM_ISSUE | mm(acc, 1) requested -> leave Montgomery form
// FROM_WAIT  | waiting for final product
// FIN        | done pulse, result valid

module mont_exp_ctrl #(
    parameter int WIDTH     = 381,
    parameter int EXP_WIDTH = 381
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r2,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_m,
    input  logic [WIDTH-1:0]     mm_result,
    input  logic                 mm_done
);

    localparam int CNT_W = 9;
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    typedef enum logic [3:0] {
        IDLE, XM_ISSUE, XM_WAIT, ONE_ISSUE, ONE_WAIT, SQR_ISSUE, SQR_WAIT,
        MUL_ISSUE, MUL_WAIT, FROM_ISSUE, FROM_WAIT, FIN
    } state_t;

    state_t               state;
    logic [EXP_WIDTH-1:0] e_reg;
    logic [WIDTH-1:0]     r2_reg;
    logic [WIDTH-1:0]     xm;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     start_idx;
    logic                 e_bit;

`ifdef MONT_EXP_SKIP_LZ_EN
    // Priority encoder: index of the highest set bit (0 when v is zero).
    function automatic logic [CNT_W-1:0] msb_index(input logic [EXP_WIDTH-1:0] v);
        msb_index = '0;
        for (int i = 0; i < EXP_WIDTH; i++) begin
            if (v[i]) msb_index = CNT_W'(i);
        end
    endfunction
`endif

    // Loop start index loaded into the bit counter when a start is accepted.
    always_comb begin
`ifdef MONT_EXP_SKIP_LZ_EN
        start_idx = msb_index(in_e);
`else
        start_idx = CNT_W'(EXP_WIDTH - 1);
`endif
    end

    assign e_bit = e_reg[cnt];

    // Sequencer. The accumulator lives in mm_a between operations: every
    // product that feeds the next step is loaded straight into the operand
    // registers in the mm_done cycle, so the next mm_start follows by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            done     <= 1'b0;
            busy     <= 1'b0;
            mm_start <= 1'b0;
            result   <= '0;
            mm_a     <= '0;
            mm_b     <= '0;
            mm_m     <= '0;
            xm       <= '0;
            cnt      <= '0;
            e_reg    <= '0;
            r2_reg   <= '0;
        end else begin
            mm_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        e_reg    <= in_e;
                        r2_reg   <= in_r2;
                        mm_m     <= in_m;
                        cnt      <= start_idx;
                        mm_a     <= in_x;
                        mm_b     <= in_r2;
                        mm_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= XM_ISSUE;
                    end
                end
                XM_ISSUE: state <= XM_WAIT;
                XM_WAIT: begin
                    if (mm_done) begin
                        xm       <= mm_result;
                        mm_a     <= r2_reg;
                        mm_b     <= ONE_W;
                        mm_start <= 1'b1;
                        state    <= ONE_ISSUE;
                    end
                end
                ONE_ISSUE: state <= ONE_WAIT;
                ONE_WAIT: begin
                    if (mm_done) begin
                        mm_a     <= mm_result;
                        mm_start <= 1'b1;
                        if (e_reg == '0) begin
                            mm_b  <= ONE_W;
                            state <= FROM_ISSUE;
                        end else begin
                            mm_b  <= mm_result;
                            state <= SQR_ISSUE;
                        end
                    end
                end
                SQR_ISSUE: state <= SQR_WAIT;
                SQR_WAIT: begin
                    if (mm_done) begin
                        mm_a     <= mm_result;
                        mm_start <= 1'b1;
                        if (e_bit) begin
                            mm_b  <= xm;
                            state <= MUL_ISSUE;
                        end else if (cnt != '0) begin
                            cnt   <= cnt - CNT_W'(1);
                            mm_b  <= mm_result;
                            state <= SQR_ISSUE;
                        end else begin
                            mm_b  <= ONE_W;
                            state <= FROM_ISSUE;
                        end
                    end
                end
                MUL_ISSUE: state <= MUL_WAIT;
                MUL_WAIT: begin
                    if (mm_done) begin
                        mm_a     <= mm_result;
                        mm_start <= 1'b1;
                        if (cnt != '0) begin
                            cnt   <= cnt - CNT_W'(1);
                            mm_b  <= mm_result;
                            state <= SQR_ISSUE;
                        end else begin
                            mm_b  <= ONE_W;
                            state <= FROM_ISSUE;
                        end
                    end
                end
                FROM_ISSUE: state <= FROM_WAIT;
                FROM_WAIT: begin
                    if (mm_done) begin
                        result <= mm_result;
                        done   <= 1'b1;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl: behavioural Montgomery multiplier with
// a per-run fixed latency, a plain modular-exponentiation reference and a
// cycle-exact timing expectation derived from the operation count.
module tb_mont_exp_ctrl;
    localparam int W  = 381;
    localparam int EW = 381;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  in_x = '0, in_m = '0, in_r2 = '0;
    logic [EW-1:0] in_e = '0;
    logic [W-1:0]  result, mm_a, mm_b, mm_m;
    logic          done, busy, mm_start;
    logic [W-1:0]  mm_result = '0;
    logic          resp_done = 1'b0;
    logic          stray = 1'b0;
    logic          mm_done;

    assign mm_done = resp_done | stray;

    mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r2(in_r2),
        .result(result), .done(done), .busy(busy),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // Expected-run state shared by driver and compare process.
    bit           run_on = 1'b0;
    int           acc_cyc = 0, done_cyc = 0, lat = 5, exp_ops = 0;
    logic [W-1:0] exp_res = '0, exp_result = '0, cur_m = '0;
    // Multiplier model state.
    bit           outst = 1'b0;
    int           cnt_r = 0, starts_seen = 0;
    logic [W-1:0] cap_a = '0, cap_b = '0, cap_m = '0;

    task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // a*b*R^-1 mod m by halving: add m whenever odd, W times.
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
        logic [2*W-1:0] p;
        logic [W:0]     t;
        p = (2*W)'(a) * (2*W)'(b);
        t = (W+1)'(p % (2*W)'(m));
        for (int i = 0; i < W; i++) begin
            if (t[0]) t = t + (W+1)'(m);
            t = t >> 1;
        end
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] modexp(input logic [W-1:0] x, input logic [EW-1:0] e,
                                            input logic [W-1:0] m);
        logic [2*W-1:0] r, b, mw;
        mw = (2*W)'(m);
        r  = (2*W)'(1) % mw;
        b  = (2*W)'(x) % mw;
        for (int i = EW - 1; i >= 0; i--) begin
            r = (r * r) % mw;
            if (e[i]) r = (r * b) % mw;
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] rmod(input logic [W-1:0] m);
        logic [W:0] t;
        t = '0;
        t[W] = 1'b1;
        return W'(t % (W+1)'(m));
    endfunction

    function automatic logic [W-1:0] r2_of(input logic [W-1:0] m);
        logic [2*W-1:0] r;
        r = (2*W)'(rmod(m));
        return W'((r * r) % (2*W)'(m));
    endfunction

    // Number of multiplier operations: xm, one, from, plus squares and multiplies.
    function automatic int ops_for(input logic [EW-1:0] e);
        int p, top;
        p = $countones(e);
        if (e == '0) return 3;
        top = EW - 1;
`ifdef MONT_EXP_SKIP_LZ_EN
        top = 0;
        for (int i = 0; i < EW; i++) if (e[i]) top = i;
`endif
        return 3 + top + 1 + p;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < 12; i++) v = (v << 32) | W'($urandom);
        return v;
    endfunction

    // Compare process plus multiplier model, evaluated mid-cycle.
    always @(negedge clk) begin
        bit e_busy, e_done, e_mms;
        e_busy = 1'b0; e_done = 1'b0; e_mms = 1'b0;
        if (run_on) begin
            e_busy = (cyc > acc_cyc) && (cyc <= done_cyc);
            e_done = (cyc == done_cyc);
            e_mms  = e_busy && (cyc < done_cyc) && (((cyc - acc_cyc - 1) % (lat + 1)) == 0);
        end
        chk_b("busy", busy, e_busy);
        chk_b("done", done, e_done);
        chk_b("mm_start", mm_start, e_mms);
        if (e_done) begin
            chk_w("result_at_done", result, exp_res);
            chk_i("mm_start_count", starts_seen, exp_ops);
        end else if (!run_on) begin
            chk_w("result_hold", result, exp_result);
        end

        resp_done = 1'b0;
        if (!run_on) outst = 1'b0;
        if (outst) begin
            chk_b("start_while_outstanding", mm_start, 1'b0);
            chk_w("mm_a_stable", mm_a, cap_a);
            chk_w("mm_b_stable", mm_b, cap_b);
            chk_w("mm_m_stable", mm_m, cap_m);
            cnt_r--;
            if (cnt_r == 0) begin
                mm_result = mont(cap_a, cap_b, cap_m);
                resp_done = 1'b1;
                outst     = 1'b0;
            end
        end
        if (mm_start && run_on) begin
            chk_w("mm_m_value", mm_m, cur_m);
            cap_a = mm_a; cap_b = mm_b; cap_m = mm_m;
            outst = 1'b1;
            cnt_r = lat;
            starts_seen++;
        end
        if (run_on && cyc >= done_cyc) begin
            run_on     = 1'b0;
            exp_result = exp_res;
        end
    end

    task automatic launch(input logic [W-1:0] x, input logic [EW-1:0] e,
                          input logic [W-1:0] m, input int l);
        @(negedge clk);
        lat   = l;
        in_x  = x; in_e = e; in_m = m; in_r2 = r2_of(m);
        start = 1'b1;
        cur_m       = m;
        exp_res     = modexp(x, e, m);
        exp_ops     = ops_for(e);
        starts_seen = 0;
        acc_cyc     = cyc;
        done_cyc    = cyc + (l + 1) * exp_ops + 1;
        run_on      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_x = rand_w(); in_e = EW'(rand_w()); in_m = rand_w(); in_r2 = rand_w();
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (run_on && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk_b("run_timeout", run_on, 1'b0);
        run_on = 1'b0;
    endtask

    initial begin
        logic [W-1:0]  m, x;
        logic [EW-1:0] e;

        repeat (3) @(negedge clk);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk_b("rst_mm_start", mm_start, 1'b0);
        chk_w("rst_result", result, '0);
        chk_w("rst_mm_a", mm_a, '0);
        reset = 1'b0;

        // Hand-computed pins: 2^381 mod 13 = 5, r2 = 25 mod 13 = 12.
        chk_w("pin_rmod13", rmod(W'(13)), W'(5));
        chk_w("pin_r2_13", r2_of(W'(13)), W'(12));
        chk_w("pin_mont_r2_1", mont(W'(12), W'(1), W'(13)), W'(5));
        chk_w("pin_mont_out", mont(W'(5), W'(1), W'(13)), W'(1));
        chk_w("pin_modexp_3_5", modexp(W'(3), EW'(5), W'(13)), W'(9));
        chk_w("pin_modexp_2_10", modexp(W'(2), EW'(10), W'(1000003)), W'(1024));
`ifdef MONT_EXP_SKIP_LZ_EN
        chk_i("pin_ops_e5", ops_for(EW'(5)), 8);
`else
        chk_i("pin_ops_e5", ops_for(EW'(5)), 386);
`endif
        chk_i("pin_ops_e0", ops_for(EW'(0)), 3);

        launch(W'(3), EW'(5), W'(13), 5);
        wait_done();
        @(negedge clk);
        chk_w("r_3_5_13", result, W'(9));

        launch(W'(2), EW'(10), W'(1000003), 5);
        wait_done();
        @(negedge clk);
        chk_w("r_2_10", result, W'(1024));

        launch(W'($urandom_range(0, 12)), EW'(0), W'(13), 5);
        wait_done();
        @(negedge clk);
        chk_w("r_e0", result, W'(1));

        // Stray mm_done while idle, then a run with a 20-cycle multiplier.
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        repeat (3) @(negedge clk);
        launch(W'(7), EW'($urandom), W'(1000003), 20);
        wait_done();

        // Start mid-run and in the FIN cycle: both ignored.
        launch(W'(11), EW'($urandom_range(1000, 60000)), W'(1000003), 5);
        while (cyc < acc_cyc + 50) @(negedge clk);
        start = 1'b1; in_x = rand_w(); in_e = EW'(rand_w()); in_m = rand_w();
        @(negedge clk); start = 1'b0;
        while (cyc < done_cyc) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);

        // Reset 100 cycles into a run: abandoned, no done pulse.
        e = EW'(rand_w());
        e[EW-1] = 1'b1;
        launch(W'(5), e, W'(1000003), 5);
        while (cyc < acc_cyc + 100) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_on = 1'b0;
        exp_result = '0;
        @(negedge clk);
        reset = 1'b0;
        chk_w("rst_mid_result", result, '0);
        chk_w("rst_mid_mm_a", mm_a, '0);
        chk_w("rst_mid_mm_b", mm_b, '0);
        chk_w("rst_mid_mm_m", mm_m, '0);
        repeat (10) @(negedge clk);
        launch(W'(2), EW'(10), W'(1000003), 5);
        wait_done();
        @(negedge clk);
        chk_w("r_after_reset", result, W'(1024));

        // Full-width modulus: (M-1)^2 mod M = 1.
        m = '1;
        launch(m - W'(1), EW'(2), m, 3);
        wait_done();
        @(negedge clk);
        chk_w("r_full_width", result, W'(1));

        // Randomized runs.
        for (int k = 0; k < 5; k++) begin
            m = rand_w() | W'(1);
            if (m == W'(1)) m = W'(3);
            x = rand_w() % m;
            if (k[0]) e = EW'($urandom);
            else      e = EW'(rand_w());
            launch(x, e, m, $urandom_range(1, 8));
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mont_exp_ctrl.md
MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 Parameter WIDTH, default 381: modulus, operand and result width in bits.
REQ-002 Parameter EXP_WIDTH, default 381: exponent width in bits; the bit counter is 9 bits wide.
REQ-003 Clocking and reset SHALL be one clock and a synchronous, active-high reset; ports are named clk and reset.
REQ-004 The ports SHALL be exactly the following (name, direction, width, meaning):
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- in_x  input  WIDTH  base; must be less than in_m
- in_e  input  EXP_WIDTH  exponent
- in_m  input  WIDTH  odd modulus, greater than 1
- in_r2  input  WIDTH  R^2 mod M, where R = 2^WIDTH
- result  output  WIDTH  x^e mod M; valid from the done pulse until the next start is accepted
- done  output  1  one-cycle completion pulse
- busy  output  1  high from the cycle after an accepted start through the done cycle
- mm_start  output  1  one-cycle operation request to the multiplier
- mm_a  output  WIDTH  multiplier operand A
- mm_b  output  WIDTH  multiplier operand B
- mm_m  output  WIDTH  multiplier modulus
- mm_result  input  WIDTH  multiplier output, a*b*R^-1 mod M
- mm_done  input  1  one-cycle multiplier completion pulse

Function
REQ-010 The block SHALL compute result = in_x^in_e mod in_m by initiating Montgomery multiplications on the mm_* port and consuming their results; it contains no multiplier of its own.
REQ-011 On an accepted start, in_x, in_e, in_m and in_r2 SHALL be registered; input changes after that cycle have no effect.
REQ-012 States SHALL be IDLE, XM, ONE, SQR, MUL, FROM, FIN. Every state except IDLE and FIN has an ISSUE and a WAIT phase.
REQ-013 The sequence SHALL be:
- XM: xm = mm(x, r2)
- ONE: acc = mm(r2, 1), i.e. R mod M
- SQR and MUL, per exponent bit from the start index down to 0: acc = mm(acc, acc); if e[i] = 1 then acc = mm(acc, xm)
- FROM: acc = mm(acc, 1)
- FIN: done = 1, result = acc
REQ-014 ISSUE phase SHALL be one cycle: mm_start = 1, with mm_a, mm_b and mm_m driven; the next state is the WAIT phase.
REQ-015 mm_a, mm_b and mm_m SHALL stay stable from the mm_start cycle through the mm_done cycle inclusive; mm_start SHALL never be asserted while an operation is outstanding.
REQ-016 In WAIT, mm_result SHALL be captured in the cycle mm_done = 1, and the following cycle is the next ISSUE phase or FIN.
REQ-017 Cycle timing: start sampled in cycle 0 gives the first mm_start in cycle 1. The next mm_start follows mm_done by exactly 1 cycle. done is asserted the cycle after the final mm_done.
REQ-018 Bit counter: after SQR, if e[i] = 0, or after MUL, the counter decrements when i > 0. At i = 0 the next state is FROM. The counter SHALL never wrap.
REQ-019 If in_e = 0, the SQR/MUL loop SHALL be skipped after ONE and result = 1.
REQ-020 start SHALL be ignored while busy = 1. start in the FIN cycle SHALL also be ignored.
REQ-021 mm_done seen outside a WAIT phase SHALL be ignored.

Reset
REQ-030 While reset is high at a clock edge, the state SHALL become IDLE, done = 0, busy = 0, mm_start = 0, result = 0, and the counter and internal acc/xm registers = 0.
REQ-031 Reset mid-operation SHALL abandon the operation with no done pulse; the system resets the multiplier with the same reset.
REQ-032 The first start after reset deassertion SHALL be accepted normally.

Configuration
REQ-040 Macro MONT_EXP_SKIP_LZ_EN SHALL control where the SQR/MUL loop starts:
- Defined: the loop starts at the index of the most significant set bit of e; the index is computed by a priority encoder at start acceptance.
- Undefined: the loop starts at EXP_WIDTH-1 and processes every bit.
- result SHALL be identical in both builds; only the mm operation count and latency differ.

Verification
(The bench uses a behavioural Montgomery model with a fixed 5-cycle latency; r2 is computed by the bench.)
REQ-050 x=3, e=5, M=13 -> result=9. Without the macro: 386 mm_start pulses. With the macro: 8 pulses.
REQ-051 x=2, e=10, M=1000003 -> result=1024. done is high for exactly 1 cycle; busy falls in the cycle after done.
REQ-052 e=0, any x, M=13 -> result=1. With the macro, exactly 3 mm_start pulses.
REQ-053 Hold the mm_done response for 20 cycles -> mm_a, mm_b and mm_m stay stable and there is no second mm_start. A stray mm_done in IDLE produces no state change.
REQ-054 Assert start again at cycle 50 of a run -> it is ignored and the first result is unchanged. Assert reset at cycle 100 -> the next cycle shows IDLE and all outputs 0, with no done pulse. A fresh start then completes correctly.
REQ-055 M = 2^WIDTH - 1, x = M-1, e = 2 -> result = 1, exercising the full-width boundary.
